dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the `data_memory` block. It shares the single data RAM between the core's load/store unit (port 0) and a debug/DMA requester (port 1), and returns one registered response per granted access. Port 0 has priority, with a bounded starvation guarantee for port 1, and out-of-range addresses are rejected without touching the RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: word-address bits decoded by the RAM; legal range 1..31.
- `MAX_WAIT`, default 4: consecutive conflict losses port 1 may suffer before it wins; legal range 1..15.

Ports:
- `clk` — in, 1: system clock; all state updates on the rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` — in, 1: access request, level, sampled every cycle.
- `p0_we`, `p1_we` — in, 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` — in, 32: word address.
- `p0_wdata`, `p1_wdata` — in, 32: write data.
- `p0_gnt`, `p1_gnt` — out, 1: combinational grant, same cycle as the request.
- `p0_done`, `p1_done` — out, 1: one-cycle response pulse, the cycle after the grant.
- `p0_rdata`, `p1_rdata` — out, 32: registered read data.
- `p0_err`, `p1_err` — out, 1: response carries an out-of-range error; valid with `done`.
- `mem_enable` — out, 1: drives the RAM enable.
- `mem_write_enable` — out, 1: drives the RAM write enable.
- `mem_address` — out, 32: drives the RAM address; bits [31:ADDR_WIDTH] are always 0.
- `mem_write_data` — out, 32: drives the RAM write data.
- `mem_data_out` — in, 32: RAM read data. The RAM samples on the falling edge of `clk`, so this input is valid before the next rising edge.
- `stat_conflicts` — out, 16: count of cycles with both requests asserted.
- `stat_p1_forced` — out, 16: count of starvation-forced port 1 wins.

## Operation
- Only one grant per cycle.
- If exactly one port requests, that port is granted.
- If both ports request, port 0 wins, unless `wait_cnt == MAX_WAIT`; in that case port 1 wins.
- `wait_cnt` (4 bits):
  - increments when `p1_req && !p1_gnt`;
  - clears when `p1_gnt` is asserted or `p1_req` is low;
  - saturates at `MAX_WAIT`.
- In-range check: `addr[31:ADDR_WIDTH] == 0`.
- In-range grant:
  - `mem_enable` = 1;
  - `mem_write_enable` = granted `we`;
  - `mem_address` = `{0, addr[ADDR_WIDTH-1:0]}`;
  - `mem_write_data` = granted `wdata`.
- Out-of-range grant:
  - the request is still granted;
  - `mem_enable` and `mem_write_enable` stay 0, so writes are dropped;
  - the response carries `err` = 1 and `rdata` = 0.
- No grant: all `mem_*` outputs are 0.
- Response register, captured at the rising edge that ends the grant cycle:
  - the granted port's `done` = 1;
  - `rdata` = `mem_data_out` for an in-range read, otherwise 0;
  - `err` = the range-check failure.
- The non-granted port's `done` = 0, and its `rdata` and `err` hold their previous values.
- Back-to-back grants are allowed, giving a throughput of one access per cycle.

## Timing
- Grant and `mem_*` outputs are combinational from the requests in cycle N.
- The RAM is accessed at the falling edge inside cycle N.
- `done`, `rdata` and `err` are valid in cycle N+1: latency 1 cycle, for reads and writes alike.
- Reset (`rst_n` = 0), applied asynchronously:
  - `done`, `rdata`, `err`, `wait_cnt` and the stats counters clear to 0;
  - `gnt` and `mem_*` are forced to 0 while reset is asserted.
- Reset mid-access: a grant issued before reset produces no `done` after reset is released.
- First cycle after reset release: normal arbitration, with `wait_cnt` = 0.

## Configuration
- Macro: `DMEM_ARB_STATS_EN`.
- Defined: the stats counters are implemented.
  - `stat_conflicts` increments on every cycle with `p0_req && p1_req`.
  - `stat_p1_forced` increments on every starvation-forced port 1 win.
  - Both counters saturate at 16'hFFFF.
- Undefined: the stats ports remain on the interface but are tied to 0, with no counter logic.

## Test plan
- Single port 0 write: addr 5, data 32'hDEADBEEF, then a port 0 read of addr 5 → `p0_done` pulses in the cycle after each grant; the read returns `p0_rdata` = 32'hDEADBEEF with `p0_err` = 0.
- Both ports read continuously, `MAX_WAIT` = 4 → port 0 is granted 4 cycles, port 1 on the 5th, and the pattern repeats; `stat_p1_forced` increments by 1 per 5 cycles when `DMEM_ARB_STATS_EN` is defined.
- Port 1 write to addr 32'h0000_1000 with `ADDR_WIDTH` = 12 → granted with `mem_enable` = 0; `p1_done` = 1 and `p1_err` = 1 next cycle; a subsequent read of addr 0 still returns the old data.
- Port 0 reads addr 1, 2, 3 back-to-back, preloaded with 32'h11, 32'h22, 32'h33 → `p0_done` is high 3 consecutive cycles, and `p0_rdata` returns 32'h11, 32'h22, 32'h33 in order.
- Assert `rst_n` = 0 mid-grant, in the cycle a port 0 read is granted → no `p0_done` after release; all outputs are 0 during reset; `wait_cnt` restarts at 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the data RAM: port 0 has priority, and port 1 is
// guaranteed a win after MAX_WAIT consecutive conflict losses. Optional stats: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_err,
  output logic        p1_err,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_data_out,
  output logic [15:0] stat_conflicts,
  output logic [15:0] stat_p1_forced
);

  localparam logic [31:0] ADDR_MASK  = 32'((64'd1 << ADDR_WIDTH) - 64'd1);
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        p0_done_q, p1_done_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;
  logic        p0_err_q, p1_err_q;

  logic        p0_in_rng, p1_in_rng;
  logic        conflict, force_p1;
  logic        sel_in_rng, sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] p0_rdata_d, p1_rdata_d;

  assign p0_in_rng = (p0_addr & ~ADDR_MASK) == 32'h0;
  assign p1_in_rng = (p1_addr & ~ADDR_MASK) == 32'h0;
  assign conflict  = p0_req && p1_req;
  assign force_p1  = conflict && (wait_cnt_q == MAX_WAIT_C);

  // Grants are masked by reset so nothing reaches the RAM while rst_n is low.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      p1_gnt = p1_req && (!p0_req || force_p1);
      p0_gnt = p0_req && !p1_gnt;
    end
  end

  always_comb begin
    sel_in_rng = 1'b0;
    sel_we     = 1'b0;
    sel_addr   = 32'h0;
    sel_wdata  = 32'h0;
    if (p0_gnt) begin
      sel_in_rng = p0_in_rng;
      sel_we     = p0_we;
      sel_addr   = p0_addr;
      sel_wdata  = p0_wdata;
    end else if (p1_gnt) begin
      sel_in_rng = p1_in_rng;
      sel_we     = p1_we;
      sel_addr   = p1_addr;
      sel_wdata  = p1_wdata;
    end
  end

  always_comb begin
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = 32'h0;
    mem_write_data   = 32'h0;
    if (sel_in_rng) begin
      mem_enable       = 1'b1;
      mem_write_enable = sel_we;
      mem_address      = sel_addr & ADDR_MASK;
      mem_write_data   = sel_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Writes and out-of-range accesses return zero data.
  assign p0_rdata_d = (p0_in_rng && !p0_we) ? mem_data_out : 32'h0;
  assign p1_rdata_d = (p1_in_rng && !p1_we) ? mem_data_out : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= 32'h0;
      p1_rdata_q <= 32'h0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      p0_done_q  <= p0_gnt;
      p1_done_q  <= p1_gnt;
      if (p0_gnt) begin
        p0_rdata_q <= p0_rdata_d;
        p0_err_q   <= !p0_in_rng;
      end
      if (p1_gnt) begin
        p1_rdata_q <= p1_rdata_d;
        p1_err_q   <= !p1_in_rng;
      end
    end
  end

  assign p0_done  = p0_done_q;
  assign p1_done  = p1_done_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts_q, stat_conflicts_d;
  logic [15:0] stat_p1_forced_q, stat_p1_forced_d;

  always_comb begin
    stat_conflicts_d = stat_conflicts_q;
    stat_p1_forced_d = stat_p1_forced_q;
    if (conflict && stat_conflicts_q != 16'hFFFF) begin
      stat_conflicts_d = stat_conflicts_q + 16'd1;
    end
    if (force_p1 && stat_p1_forced_q != 16'hFFFF) begin
      stat_p1_forced_d = stat_p1_forced_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts_q <= 16'h0;
      stat_p1_forced_q <= 16'h0;
    end else begin
      stat_conflicts_q <= stat_conflicts_d;
      stat_p1_forced_q <= stat_p1_forced_d;
    end
  end

  assign stat_conflicts = stat_conflicts_q;
  assign stat_p1_forced = stat_p1_forced_q;
`else
  assign stat_conflicts = 16'h0;
  assign stat_p1_forced = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model of arbitration, memory contents and responses.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int MW = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_enable, mem_write_enable;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_data_out = 32'h0;
  logic [15:0] stat_conflicts, stat_p1_forced;

  int n_checks = 0;
  int n_fail = 0;

  // RAM environment and reference model state
  logic [31:0] ram     [0:DEPTH-1];
  logic [31:0] mdl_mem [0:DEPTH-1];
  int          mdl_wait;
  logic [31:0] e_rdata [2];
  logic        e_err   [2];
  int          e_conf, e_forced;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_err(p0_err), .p1_err(p1_err),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_data_out(mem_data_out),
    .stat_conflicts(stat_conflicts), .stat_p1_forced(stat_p1_forced)
  );

  always @(negedge clk) begin
    if (mem_enable) begin
      if (mem_write_enable) ram[mem_address[AW-1:0]] <= mem_write_data;
      else mem_data_out <= ram[mem_address[AW-1:0]];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_stat(input int v);
`ifdef DMEM_ARB_STATS_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  task automatic model_reset();
    mdl_wait = 0;
    e_rdata[0] = 0; e_rdata[1] = 0;
    e_err[0] = 0;   e_err[1] = 0;
    e_conf = 0;     e_forced = 0;
  endtask

  // One cycle: drive at posedge+1, check grant/mem at +2, check response at next posedge+1.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic g0, g1, ok, we;
    logic [31:0] a, d;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    g1 = r1 && (!r0 || mdl_wait == MW);
    g0 = r0 && !g1;
    a  = g0 ? a0 : a1;
    d  = g0 ? d0 : d1;
    we = g0 ? w0 : w1;
    ok = (g0 || g1) && (a < DEPTH);
    check_val("p0_gnt", 32'(p0_gnt), 32'(g0));
    check_val("p1_gnt", 32'(p1_gnt), 32'(g1));
    check_val("mem_enable", 32'(mem_enable), 32'(ok));
    check_val("mem_write_enable", 32'(mem_write_enable), 32'(ok && we));
    check_val("mem_address", mem_address, ok ? a : 32'h0);
    check_val("mem_write_data", mem_write_data, ok ? d : 32'h0);
    if (g0 || g1) begin
      e_rdata[g1] = (ok && !we) ? mdl_mem[a[AW-1:0]] : 32'h0;
      e_err[g1]   = !(a < DEPTH);
      if (ok && we) mdl_mem[a[AW-1:0]] = d;
    end
    if (r0 && r1 && e_conf < 65535) e_conf++;
    if (r0 && g1 && e_forced < 65535) e_forced++;
    if (!r1 || g1) mdl_wait = 0;
    else if (mdl_wait < MW) mdl_wait++;
    @(posedge clk); #1;
    check_val("p0_done", 32'(p0_done), 32'(g0));
    check_val("p1_done", 32'(p1_done), 32'(g1));
    check_val("p0_rdata", p0_rdata, e_rdata[0]);
    check_val("p1_rdata", p1_rdata, e_rdata[1]);
    check_val("p0_err", 32'(p0_err), 32'(e_err[0]));
    check_val("p1_err", 32'(p1_err), 32'(e_err[1]));
    check_val("stat_conflicts", 32'(stat_conflicts), 32'(exp_stat(e_conf)));
    check_val("stat_p1_forced", 32'(stat_p1_forced), 32'(exp_stat(e_forced)));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_gnt"}, {30'h0, p1_gnt, p0_gnt}, 32'h0);
    check_val({tag, "_done"}, {30'h0, p1_done, p0_done}, 32'h0);
    check_val({tag, "_err"}, {30'h0, p1_err, p0_err}, 32'h0);
    check_val({tag, "_rdata0"}, p0_rdata, 32'h0);
    check_val({tag, "_rdata1"}, p1_rdata, 32'h0);
    check_val({tag, "_mem_ctl"}, {30'h0, mem_write_enable, mem_enable}, 32'h0);
    check_val({tag, "_mem_addr"}, mem_address, 32'h0);
    check_val({tag, "_mem_wdata"}, mem_write_data, 32'h0);
    check_val({tag, "_stats"}, {stat_p1_forced, stat_conflicts}, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = (i >= 1 && i <= 3) ? 32'(i * 17) : 32'h0;
      ram[i] = v;
      mdl_mem[i] = v;
    end
    model_reset();

    // Reset state, with a request pending to confirm grants are masked
    p0_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    p0_req = 1'b0;
    rst_n = 1'b1;

    // Single port 0 write then read
    step(1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 32'd5, 32'h0, 0, 0, 0, 0);
    check_val("p0_read_back_5", p0_rdata, 32'hDEADBEEF);

    // Continuous conflict: port 1 forced in on every 5th cycle
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0);
      check_val("pattern_p1_done", 32'(p1_done), 32'((i % 5) == 4));
    end

    // Out-of-range write by port 1 is dropped and flagged
    step(0, 0, 0, 0, 1, 1, 32'h0000_1000, 32'hCAFEF00D);
    check_val("oor_p1_err", 32'(p1_err), 32'h1);
    step(0, 0, 0, 0, 1, 0, 32'h0, 0);
    check_val("oor_read_addr0", p1_rdata, 32'h0);

    // Back-to-back port 0 reads
    step(1, 0, 32'd1, 0, 0, 0, 0, 0);
    check_val("b2b_1", p0_rdata, 32'h11);
    step(1, 0, 32'd2, 0, 0, 0, 0, 0);
    check_val("b2b_2", p0_rdata, 32'h22);
    step(1, 0, 32'd3, 0, 0, 0, 0, 0);
    check_val("b2b_3", p0_rdata, 32'h33);
    idle();

    // Random traffic over a small hot address window plus occasional out-of-range
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a0, a1;
      a0 = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), a0, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom), a1, $urandom);
    end

    // Reset asserted inside a port 0 read grant cycle
    step(1, 0, 32'd1, 0, 1, 0, 32'd2, 0);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd3;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd2;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    check_reset_outputs("midreset_edge");
    p0_req = 0; p1_req = 0;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_val("post_reset_no_done", {30'h0, p1_done, p0_done}, 32'h0);
    idle();
    for (int i = 0; i < 5; i++) step(1, 0, 32'd2, 0, 1, 0, 32'd3, 0);
    check_val("post_reset_p1_5th", 32'(p1_done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
